// File: rtl/crc_serial_engine.sv
// -----------------------------------------------------------------------------
// crc_serial_engine
//   Bit-serial CRC engine. It accepts one byte at a time and shifts it through
//   the CRC register one bit per enabled clock, so a byte takes 8 cycles.
//   Back-to-back bytes are accepted on the edge of the final shift of the
//   previous byte. When a frame completes (its last byte is absorbed), the
//   next accepted byte automatically restarts from INIT.
//
//   Parameters : CRC_W (2..32), POLY (implicit x^CRC_W term), INIT (seed)
//   Ports      : clk, rst_n (async active-low)
//                enable       - high advances the engine, low stalls everything
//                clr          - synchronous clear to seed, drops any byte in flight
//                in_data[7:0], in_valid, in_last, in_ready - byte handshake
//                crc_out      - CRC register contents (bit-reversed in LSB build)
//                byte_done    - one-cycle pulse after a byte is fully absorbed
//                crc_valid    - crc_out holds a finished frame CRC
//   Build option: define CRC_SERIAL_LSB_FIRST_EN to shift each byte LSB first
//                 and present crc_out bit-reversed.
// -----------------------------------------------------------------------------
module crc_serial_engine #(
    parameter int                 CRC_W = 8,
    parameter logic [CRC_W-1:0]   POLY  = 8'h07,
    parameter logic [CRC_W-1:0]   INIT  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clr,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [CRC_W-1:0]  crc_out,
    output logic              byte_done,
    output logic              crc_valid
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    logic             state_r;
    logic [2:0]       count_r;
    logic [7:0]       shreg_r;
    logic             last_r;
    logic             fresh_r;      // next shift starts from INIT (frame restart)
    logic [CRC_W-1:0] crc_r;
    logic             byte_done_r;
    logic             crc_valid_r;

    logic             ready_s;
    logic             accept_s;
    logic             cur_bit_s;
    logic             fb_s;
    logic [CRC_W-1:0] crc_base_s;
    logic [CRC_W-1:0] crc_next_s;

    function automatic logic [CRC_W-1:0] bit_reverse(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        r = '0;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = v[CRC_W-1-i];
        end
        return r;
    endfunction

    // Handshake, current bit selection and next CRC value.
    always_comb begin
        ready_s = 1'b0;
        if (rst_n && enable && !clr &&
            ((state_r == ST_IDLE) || (count_r == 3'd7))) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        accept_s = in_valid & ready_s;
`ifdef CRC_SERIAL_LSB_FIRST_EN
        cur_bit_s = shreg_r[count_r];
`else
        cur_bit_s = shreg_r[3'd7 - count_r];
`endif
        // After a completed frame the stale result is still on crc_r; the
        // first shift of the new frame must start from the seed instead.
        if (fresh_r) begin
            crc_base_s = INIT;
        end else begin
            crc_base_s = crc_r;
        end
        fb_s       = crc_base_s[CRC_W-1] ^ cur_bit_s;
        crc_next_s = {crc_base_s[CRC_W-2:0], 1'b0} ^ (fb_s ? POLY : {CRC_W{1'b0}});
    end

    // Engine state: byte capture, bit shifting, done/valid flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            count_r     <= 3'd0;
            shreg_r     <= 8'h00;
            last_r      <= 1'b0;
            fresh_r     <= 1'b0;
            crc_r       <= INIT;
            byte_done_r <= 1'b0;
            crc_valid_r <= 1'b0;
        end else if (clr) begin
            state_r     <= ST_IDLE;
            count_r     <= 3'd0;
            shreg_r     <= 8'h00;
            last_r      <= 1'b0;
            fresh_r     <= 1'b0;
            crc_r       <= INIT;
            byte_done_r <= 1'b0;
            crc_valid_r <= 1'b0;
        end else if (enable) begin
            byte_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r     <= ST_SHIFT;
                        count_r     <= 3'd0;
                        shreg_r     <= in_data;
                        last_r      <= in_last;
                        crc_valid_r <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    crc_r   <= crc_next_s;
                    fresh_r <= 1'b0;
                    count_r <= count_r + 3'd1;
                    if (count_r == 3'd7) begin
                        byte_done_r <= 1'b1;
                        crc_valid_r <= last_r;
                        fresh_r     <= last_r;
                        if (accept_s) begin
                            // Count wraps to 0: the new byte starts shifting next cycle.
                            state_r <= ST_SHIFT;
                            shreg_r <= in_data;
                            last_r  <= in_last;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        // A result left valid by a back-to-back restart is
                        // overwritten by this shift.
                        crc_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    count_r <= 3'd0;
                end
            endcase
        end else begin
            byte_done_r <= 1'b0;
        end
    end

    assign in_ready  = ready_s;
    assign byte_done = byte_done_r;
    assign crc_valid = crc_valid_r;
`ifdef CRC_SERIAL_LSB_FIRST_EN
    assign crc_out   = bit_reverse(crc_r);
`else
    assign crc_out   = crc_r;
`endif

endmodule

// File: doc/crc_serial_engine.md
CRC_SERIAL_ENGINE -- requirements
Module: crc_serial_engine

Interface
REQ-001 Parameter CRC_W, default 8: CRC register width, legal range 2..32.
REQ-002 Parameter POLY, default 8'h07: generator polynomial, CRC_W bits, implicit x^CRC_W term.
REQ-003 Parameter INIT, default 0: CRC seed, CRC_W bits.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  high = engine advances; low = full stall, all state held.
REQ-007 clr  input  1  synchronous clear to seed, discards any byte in flight.
REQ-008 in_data  input  8  byte to absorb.
REQ-009 in_valid  input  1  in_data/in_last valid.
REQ-010 in_last  input  1  byte is final byte of frame.
REQ-011 in_ready  output  1  engine can accept a byte this cycle.
REQ-012 crc_out  output  CRC_W  current CRC register contents.
REQ-013 byte_done  output  1  one-cycle pulse, a byte has been fully absorbed.
REQ-014 crc_valid  output  1  crc_out holds a finished frame CRC.

Function
REQ-015 Byte accepted on a rising edge where in_valid, in_ready and enable are all high; in_last is captured with it.
REQ-016 States: IDLE (no byte held) and SHIFT (byte held, 3-bit bit counter 0..7).
REQ-017 in_ready = enable & ~clr & (IDLE | (SHIFT & count==7)); back-to-back bytes sustain 8 cycles/byte.
REQ-018 Each enabled SHIFT cycle: fb = crc[CRC_W-1] ^ cur_bit; crc <= {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0); count increments.
REQ-019 cur_bit is the byte MSB first: bit 7 on count 0, bit 0 on count 7.
REQ-020 After the count==7 shift: go to SHIFT with count 0 if a new byte is accepted on the same edge, else go to IDLE.
REQ-021 byte_done is registered and high for exactly one cycle after each count==7 shift edge.
REQ-022 If that byte carried in_last, crc_valid goes high on the same edge as byte_done.
REQ-023 crc_valid stays high until the next byte is accepted or clr is applied.
REQ-024 crc_out holds the frame CRC while crc_valid is high.
REQ-025 Frame restart: a byte accepted after a completed frame starts from INIT, i.e. its first shift uses INIT as the previous crc; no clr is needed between frames.
REQ-026 enable low: counter, shift register, crc, state and crc_valid are held; byte_done is forced low; in_ready is low.
REQ-027 clr high (enable ignored): on that edge crc <= INIT, state <= IDLE, count <= 0, crc_valid <= 0, byte_done <= 0; any in-flight byte is dropped.
REQ-028 clr has priority over acceptance; in_ready is low in any cycle with clr high.
REQ-029 in_valid asserted while in_ready is low SHALL NOT alter state; the source holds the byte.

Reset
REQ-030 rst_n low asynchronously forces: crc=INIT, state IDLE, count 0, shift register 0, byte_done 0, crc_valid 0.
REQ-031 rst_n low forces in_ready low; in_ready returns high in the first cycle after rst_n deasserts, with enable high and clr low.
REQ-032 Reset asserted mid-byte discards that byte; no byte_done is produced for it.

Configuration
REQ-033 Macro CRC_SERIAL_LSB_FIRST_EN is the single configuration option.
REQ-034 With CRC_SERIAL_LSB_FIRST_EN defined, cur_bit is taken LSB first (bit 0 on count 0), and crc_out presents the CRC register bit-reversed.
REQ-035 Without CRC_SERIAL_LSB_FIRST_EN, the order is MSB first as in REQ-019 and crc_out is unreversed.
REQ-036 Handshake, latency and reset behaviour SHALL be identical in both builds.

Verification (CRC_W=8, POLY=8'h07, INIT=0 unless noted)
REQ-037 Single byte 8'h01 with last -> byte_done 8 cycles after accept; crc_out=8'h07; crc_valid=1.
REQ-038 ASCII "123456789" streamed back-to-back, last on '9' -> 9 byte_done pulses 8 cycles apart; final crc_out=8'hF4.
REQ-039 Two frames: first 8'h01 (last), then 8'h01 (last) with no clr -> second result also 8'h07 (auto restart).
REQ-040 clr asserted at count 4 of byte 8'hFF -> crc_out=INIT next cycle; no byte_done; in_ready high the following cycle.
REQ-041 enable held low for 5 cycles mid-byte on 8'h01 -> byte_done delayed by exactly 5 cycles; crc_out=8'h07.
REQ-042 LSB-first build, byte 8'h80 with last -> crc_out=8'hE0, the bit-reverse of 8'h07.
